// File: rtl/isqrt_pkg.sv
//------------------------------------------------------------------------------
// isqrt_pkg
//------------------------------------------------------------------------------
// Shared definitions for the sequential integer square-root unit:
//   - FSM state enumeration
//   - default radicand width and derived root/remainder widths
//   - width helper functions for parameterised instances
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package isqrt_pkg;

  // Default radicand width: holds the full x*x + y*y value of the datapath.
  localparam int DEFAULT_WIDTH = 16;

  // Root width and remainder width for the default radicand width.
  localparam int R     = DEFAULT_WIDTH / 2;
  localparam int REM_W = R + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width for an arbitrary (even) radicand width.
  function automatic int root_w(input int width);
    return width / 2;
  endfunction

  // Remainder width: remainder <= 2*root, so one bit more than the root.
  function automatic int rem_w(input int width);
    return (width / 2) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_step.sv
//------------------------------------------------------------------------------
// isqrt_step
//------------------------------------------------------------------------------
// One iteration of the restoring digit-by-digit square root: brings in the
// next two radicand bits, tries to set the next root bit and keeps the
// remainder if the trial subtraction does not go negative.
// Purely combinational.
//
// Ports:
//   rem_i   [ROOT_W:0]    partial remainder before this step
//   root_i  [ROOT_W-1:0]  partial root before this step
//   bits_i  [1:0]         next two radicand bits (MSB first)
//   rem_o   [ROOT_W:0]    partial remainder after this step
//   root_o  [ROOT_W-1:0]  partial root after this step
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int ROOT_W = R
) (
  input  logic [ROOT_W:0]   rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        bits_i,
  output logic [ROOT_W:0]   rem_o,
  output logic [ROOT_W-1:0] root_o
);

  logic [ROOT_W+2:0] rem_sh;   // (rem << 2) | bits
  logic [ROOT_W+1:0] trial;    // (root << 2) | 1
  logic [ROOT_W:0]   diff;
  logic              take;

  assign rem_sh = {rem_i, bits_i};
  assign trial  = {root_i, 2'b01};
  assign take   = (rem_sh >= {1'b0, trial});

  // When the trial is taken the true difference is <= 2*root_next and fits
  // in ROOT_W+1 bits, so subtracting only the low bits gives the exact value.
  assign diff   = rem_sh[ROOT_W:0] - trial[ROOT_W:0];

  assign rem_o  = take ? diff : rem_sh[ROOT_W:0];

  // The top root bit is always clear before the final step, so the shift
  // never loses information.
  assign root_o = {root_i[ROOT_W-2:0], take};

endmodule

`default_nettype wire

// File: rtl/isqrt_seq.sv
//------------------------------------------------------------------------------
// isqrt_seq
//------------------------------------------------------------------------------
// Sequential integer square root: root = floor(sqrt(radicand)),
// remainder = radicand - root^2. One root bit per enabled clock,
// valid/ready handshake on both sides, global clock enable.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; 0 freezes all state, no handshake completes
//   in_valid   radicand present
//   in_ready   unit can accept a radicand (IDLE)
//   radicand   [WIDTH-1:0] unsigned operand, sampled on the accepting edge
//   out_valid  result present (DONE)
//   out_ready  consumer accepts result
//   root       [WIDTH/2-1:0] floor(sqrt(radicand))
//   remainder  [WIDTH/2:0]   radicand - root^2
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       radicand,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [root_w(WIDTH)-1:0] root,
  output logic [rem_w(WIDTH)-1:0]  remainder
);

  localparam int ROOT_W = root_w(WIDTH);
  localparam int RMD_W  = rem_w(WIDTH);
  localparam int ITER_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [ITER_W-1:0] ITER_INIT = ITER_W'(ROOT_W - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("isqrt_seq: WIDTH must be even and at least 4");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_q,    sh_d;
  logic [ROOT_W-1:0]   root_q,  root_d;
  logic [RMD_W-1:0]    rem_q,   rem_d;
  logic [ITER_W-1:0]   iter_q,  iter_d;

  logic [ROOT_W-1:0]   step_root;
  logic [RMD_W-1:0]    step_rem;

  isqrt_step #(
    .ROOT_W (ROOT_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (sh_q[WIDTH-1:WIDTH-2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    root_d    = root_q;
    rem_d     = rem_q;
    iter_d    = iter_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    // Handshake flags depend on state only, never on in_valid/out_ready.
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_d    = radicand;
            root_d  = '0;
            rem_d   = '0;
            iter_d  = ITER_INIT;
            state_d = CALC;
          end
        end
        CALC: begin
          sh_d   = {sh_q[WIDTH-3:0], 2'b00};
          root_d = step_root;
          rem_d  = step_rem;
          if (iter_q == '0) begin
            state_d = DONE;
          end else begin
            iter_d = iter_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign root      = root_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_isqrt_seq.sv
//------------------------------------------------------------------------------
// tb_isqrt_seq
//------------------------------------------------------------------------------
// Self-checking bench for isqrt_seq (WIDTH=16): directed cases for reset,
// latency, back-pressure, enable stall and mid-computation reset, then a
// randomized sweep scored against an arithmetic square-root model.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_isqrt_seq;

  localparam int WIDTH   = 16;
  localparam int RW      = WIDTH / 2;
  localparam int N_SWEEP = 2500;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  radicand;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     root;
  logic [RW:0]       remainder;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  isqrt_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .remainder (remainder)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, found by plain search.
  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick_rad();
    int k;
    k = $urandom_range(1, 255);
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'(k * k);
      2:       return 16'(k * k - 1);
      3:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // Present a radicand and return at the negedge after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] value, input string tag);
    int t = 0;
    in_valid = 1'b1;
    radicand = value;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge to out_valid; optional ena stall.
  task automatic wait_result(input int stall_at, input int stall_len, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (lat == stall_at)             ena = 1'b0;
      if (lat == stall_at + stall_len) ena = 1'b1;
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after_hs"},  32'(in_ready),  32'd1);
  endtask

  task automatic directed(input logic [WIDTH-1:0] value, input int exp_root,
                          input int exp_rem, input string tag);
    int lat;
    send(value, tag);
    wait_result(-1, 0, lat);
    check({tag, "_latency"},   32'(lat),       32'(RW));
    check({tag, "_root"},      32'(root),      32'(exp_root));
    check({tag, "_remainder"}, 32'(remainder), 32'(exp_rem));
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    complete(tag);
  endtask

  initial begin
    int lat;
    int q[$];
    int done_cnt;
    int cyc;
    int x;
    int r;

    rst_n     = 1'b0;
    ena       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    radicand  = '0;
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_root",      32'(root),      32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);

    directed(16'd0,     0,   0,   "rad0");
    directed(16'd144,   12,  0,   "rad144");
    directed(16'd200,   14,  4,   "rad200");
    directed(16'd65535, 255, 510, "rad65535");

    // Back-pressure: result must hold while the consumer stalls.
    send(16'd50000, "bp");
    wait_result(-1, 0, lat);
    check("bp_latency", 32'(lat), 32'(RW));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_root",      32'(root),      32'd223);
      check("bp_remainder", 32'(remainder), 32'd271);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    complete("bp");

    // Enable stall of 3 cycles mid-computation adds 3 cycles of latency.
    send(16'd1000, "stall");
    wait_result(3, 3, lat);
    check("stall_latency",   32'(lat),       32'(RW + 3));
    check("stall_root",      32'(root),      32'd31);
    check("stall_remainder", 32'(remainder), 32'd39);
    complete("stall");

    // Asynchronous reset during the 4th computation cycle.
    send(16'd50000, "rstmid");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_in_ready",  32'(in_ready),  32'd1);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_root",      32'(root),      32'd0);
    check("rstmid_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    directed(16'd81, 9, 0, "rad81");

    // Random sweep with random enable and back-pressure.
    done_cnt = 0;
    cyc      = 0;
    while (done_cnt < N_SWEEP && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      ena       = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) < 3);
      if (in_ready) begin
        if (!in_valid) begin
          in_valid = 1'b1;
          radicand = pick_rad();
        end
      end else begin
        // Busy: in_valid and radicand are ignored, so scramble them.
        in_valid = 1'($urandom_range(0, 1));
        radicand = pick_rad();
      end
      if (in_valid && in_ready && ena) q.push_back(int'(radicand));
      if (out_valid && out_ready && ena) begin
        if (q.size() == 0) begin
          check("sweep_spurious_result", 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          r = ref_root(x);
          check("sweep_root",      32'(root),      32'(r));
          check("sweep_remainder", 32'(remainder), 32'(x - r * r));
          done_cnt++;
        end
      end
    end
    check("sweep_completed", 32'(done_cnt), 32'(N_SWEEP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
